// File: rtl/rst_seq_pkg.sv
// Shared types and parameter limits for the reset sequencer.
// Holds the sequencer state enum and a range-check helper.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } seq_state_e;

    localparam int SYNC_MIN    = 2;
    localparam int SYNC_MAX    = 8;
    localparam int HOLD_MIN    = 1;
    localparam int HOLD_MAX    = (1 << 26) - 1;
    localparam int N_OUT_MIN   = 1;
    localparam int N_OUT_MAX   = 8;
    localparam int STAGGER_MIN = 1;
    localparam int STAGGER_MAX = 255;
    localparam int STRETCH_MIN = 1;
    localparam int STRETCH_MAX = 15;

    function automatic logic in_range(input int v, input int lo, input int hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for one asynchronous bit.
// All stages clear to 0 under the synchronous reset.
module sync_bit #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] sync_q;
    logic [DEPTH-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[DEPTH-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[DEPTH-1];

endmodule

// File: rtl/rst_sequencer.sv
// Staged reset sequencer: hold timer, staggered channel release, stretched fifo_rst.
// Define RST_SEQ_INIT_GATE_EN to hold the last channel until init_done is high.
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 4,
    parameter int HOLD_CYCLES = 50000000,
    parameter int N_OUT       = 3,
    parameter int STAGGER     = 8,
    parameter int STRETCH     = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_in,
    input  logic             pll_lock,
    input  logic             init_done,
    output logic [N_OUT-1:0] rst_out,
    output logic             fifo_rst,
    output logic             seq_done
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int SW = (STAGGER > 1) ? $clog2(STAGGER) : 1;
    localparam int IW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);
    localparam logic [SW-1:0] STAG_LOAD = SW'(STAGGER - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(N_OUT - 1);

    if (!in_range(SYNC_STAGES, SYNC_MIN, SYNC_MAX) ||
        !in_range(HOLD_CYCLES, HOLD_MIN, HOLD_MAX) ||
        !in_range(N_OUT, N_OUT_MIN, N_OUT_MAX) ||
        !in_range(STAGGER, STAGGER_MIN, STAGGER_MAX) ||
        !in_range(STRETCH, STRETCH_MIN, STRETCH_MAX)) begin : g_bad_param
        $error("rst_sequencer: parameter out of legal range");
    end

    logic btn_s;
    logic lock_s;
    logic init_ok;
    logic trigger;

    sync_bit #(.DEPTH(SYNC_STAGES)) u_sync_btn (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (btn_s)
    );

    sync_bit #(.DEPTH(SYNC_STAGES)) u_sync_lock (
        .clk (clk),
        .rst (rst),
        .d   (pll_lock),
        .q   (lock_s)
    );

`ifdef RST_SEQ_INIT_GATE_EN
    assign init_ok = init_done;
`else
    logic unused_init_done;
    assign unused_init_done = init_done;
    assign init_ok = 1'b1;
`endif

    seq_state_e       state_q, state_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [SW-1:0]    stag_q, stag_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [N_OUT-1:0] rst_out_q, rst_out_d;
    logic [STRETCH-1:0] hist_q, hist_d;
    logic             btn_prev_q, btn_prev_d;

    // A held button only counts once; a lost lock keeps re-triggering.
    assign trigger = (btn_s & ~btn_prev_q) | ~lock_s;

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        stag_d     = stag_q;
        idx_d      = idx_q;
        rst_out_d  = rst_out_q;
        hist_d     = (hist_q << 1) | STRETCH'(rst_out_q[0]);
        btn_prev_d = btn_s;

        unique case (state_q)
            HOLD: begin
                rst_out_d = '1;
                if (trigger) begin
                    hold_d = HOLD_LOAD;
                end else if (hold_q != '0) begin
                    hold_d = hold_q - HW'(1);
                end else if (N_OUT == 1) begin
                    if (init_ok) begin
                        rst_out_d = '0;
                        state_d   = RUN;
                    end
                end else begin
                    rst_out_d[0] = 1'b0;
                    stag_d       = STAG_LOAD;
                    idx_d        = IW'(1);
                    state_d      = RELEASE;
                end
            end
            RELEASE: begin
                if (trigger) begin
                    state_d   = HOLD;
                    hold_d    = HOLD_LOAD;
                    rst_out_d = '1;
                    stag_d    = '0;
                    idx_d     = '0;
                end else if (stag_q != '0) begin
                    stag_d = stag_q - SW'(1);
                end else if (idx_q == LAST_IDX) begin
                    // Last channel waits here for init_done when gating is built in.
                    if (init_ok) begin
                        rst_out_d[idx_q] = 1'b0;
                        state_d          = RUN;
                    end
                end else begin
                    rst_out_d[idx_q] = 1'b0;
                    idx_d            = idx_q + IW'(1);
                    stag_d           = STAG_LOAD;
                end
            end
            RUN: begin
                if (trigger) begin
                    state_d   = HOLD;
                    hold_d    = HOLD_LOAD;
                    rst_out_d = '1;
                    stag_d    = '0;
                    idx_d     = '0;
                end
            end
            default: begin
                state_d   = HOLD;
                hold_d    = HOLD_LOAD;
                rst_out_d = '1;
                stag_d    = '0;
                idx_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HOLD;
            hold_q     <= HOLD_LOAD;
            stag_q     <= '0;
            idx_q      <= '0;
            rst_out_q  <= '1;
            hist_q     <= '0;
            btn_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            stag_q     <= stag_d;
            idx_q      <= idx_d;
            rst_out_q  <= rst_out_d;
            hist_q     <= hist_d;
            btn_prev_q <= btn_prev_d;
        end
    end

    assign rst_out  = rst_out_q;
    assign fifo_rst = rst_out_q[0] | (|hist_q);
    assign seq_done = (state_q == RUN) & ~fifo_rst;

endmodule

// File: tb/tb_rst_sequencer.sv
// Scoreboard bench for rst_sequencer with a timeline-based reference model.
// Honours RST_SEQ_INIT_GATE_EN when the design is built with it.
module tb_rst_sequencer;

    localparam int SYNC = 2;
    localparam int HOLD_N = 10;
    localparam int NOUT = 3;
    localparam int STAG = 4;
    localparam int STR = 3;
    localparam int MAXE = 4096;

`ifdef RST_SEQ_INIT_GATE_EN
    localparam bit GATE = 1'b1;
`else
    localparam bit GATE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_in = 1'b0;
    logic pll_lock = 1'b0;
    logic init_done = 1'b0;
    logic [NOUT-1:0] rst_out;
    logic fifo_rst;
    logic seq_done;

    rst_sequencer #(
        .SYNC_STAGES (SYNC),
        .HOLD_CYCLES (HOLD_N),
        .N_OUT       (NOUT),
        .STAGGER     (STAG),
        .STRETCH     (STR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .pll_lock  (pll_lock),
        .init_done (init_done),
        .rst_out   (rst_out),
        .fifo_rst  (fifo_rst),
        .seq_done  (seq_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NOUT-1:0] ro;
        logic            fr;
        logic            sd;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad = 0;

    // Reference model: input history plus time since rst_out[0] fell.
    bit lk_in[MAXE];
    bit bt_in[MAXE];
    int e = 0;
    int last_rst = 0;
    int hold_left = HOLD_N;
    int rel = -1;
    bit last_done = 1'b0;

    function automatic bit synced(input bit is_btn, input int x);
        int src;
        src = x - SYNC + 1;
        if (x < 0 || src <= last_rst) return 1'b0;
        return is_btn ? bt_in[src] : lk_in[src];
    endfunction

    task automatic model(input bit r, input bit b, input bit l, input bit i);
        bit trig;
        exp_t x;
        lk_in[e] = l;
        bt_in[e] = b;
        if (r) begin
            last_rst = e;
            hold_left = HOLD_N;
            rel = -1;
            last_done = 1'b0;
        end else begin
            trig = !synced(1'b0, e - 1) ||
                   (synced(1'b1, e - 1) && !synced(1'b1, e - 2));
            if (rel < 0) begin
                if (trig) hold_left = HOLD_N;
                else if (hold_left == 0) rel = 0;
                else hold_left--;
            end else if (trig) begin
                rel = -1;
                hold_left = HOLD_N;
                last_done = 1'b0;
            end else begin
                if (rel < 100000) rel++;
                if (rel >= (NOUT - 1) * STAG && (!GATE || i)) last_done = 1'b1;
            end
        end
        for (int k = 0; k < NOUT; k++) begin
            if (k == NOUT - 1) x.ro[k] = !last_done;
            else x.ro[k] = !(rel >= k * STAG);
        end
        x.fr = !(rel >= STR);
        x.sd = last_done && (rel >= STR);
        exp_q.push_back(x);
        if (e < MAXE - 1) e++;
    endtask

    task automatic step(input bit r, input bit b, input bit l, input bit i);
        rst = r;
        btn_in = b;
        pll_lock = l;
        init_done = i;
        model(r, b, l, i);
        @(posedge clk);
        #1;
    endtask

    // Cycle count since the last edge that sampled rst high.
    int cyc = 0;
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    int fall[5];
    logic [4:0] prev_v = '0;
    logic [4:0] cur_v;
    exp_t got;
    exp_t want;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got = {rst_out, fifo_rst, seq_done};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL outputs cyc=%0d actual ro=%b fr=%b sd=%b required ro=%b fr=%b sd=%b",
                         cyc, got.ro, got.fr, got.sd, want.ro, want.fr, want.sd);
            end
        end
        cur_v = {~seq_done, fifo_rst, rst_out};
        for (int b = 0; b < 5; b++) begin
            if (prev_v[b] === 1'b1 && cur_v[b] === 1'b0 && fall[b] < 0) fall[b] = cyc;
        end
        prev_v = cur_v;
    end

    task automatic clear_rec();
        for (int b = 0; b < 5; b++) fall[b] = -1;
    endtask

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    initial begin
        int lo_left;
        int bt_left;
        bit r;
        bit b;
        bit l;
        bit i;
        lo_left = 0;
        bt_left = 0;

        // Power-up release with lock steady; init_done rises at cycle 40.
        clear_rec();
        repeat (3) step(1'b1, 1'b0, 1'b1, 1'b0);
        for (int c = 1; c <= 50; c++) step(1'b0, 1'b0, 1'b1, c >= 40);
        chk("rst_out0_fall", fall[0], 13);
        chk("rst_out1_fall", fall[1], 17);
        chk("rst_out2_fall", fall[2], GATE ? 40 : 21);
        chk("fifo_rst_fall", fall[3], 16);
        chk("seq_done_rise", fall[4], GATE ? 40 : 21);

        // One-cycle lock glitch at cycle 5 restarts the hold count.
        clear_rec();
        step(1'b1, 1'b0, 1'b1, 1'b1);
        for (int c = 1; c <= 40; c++) step(1'b0, 1'b0, c != 5, 1'b1);
        chk("glitch_rst_out0_fall", fall[0], 18);
        chk("glitch_rst_out2_fall", fall[2], 26);

        // Five-cycle button pulse in RUN, first sampled at cycle 41.
        clear_rec();
        repeat (5) step(1'b0, 1'b1, 1'b1, 1'b1);
        repeat (45) step(1'b0, 1'b0, 1'b1, 1'b1);
        chk("btn_rst_out0_fall", fall[0], 54);
        chk("btn_seq_done_rise", fall[4], 62);

        // Stuck button: one sequence then RUN.
        repeat (80) step(1'b0, 1'b1, 1'b1, 1'b1);
        repeat (10) step(1'b0, 1'b0, 1'b1, 1'b1);

        // Button one cycle after rst_out[1] falls, then rst mid-RELEASE.
        step(1'b1, 1'b0, 1'b1, 1'b1);
        for (int c = 1; c <= 40; c++) step(1'b0, c == 18, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        for (int c = 1; c <= 18; c++) step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        repeat (30) step(1'b0, 1'b0, 1'b1, 1'b1);

        // Random mix of resets, lock drops, button pulses and init_done.
        for (int n = 0; n < 2000; n++) begin
            r = ($urandom_range(0, 399) == 0);
            if (lo_left == 0 && $urandom_range(0, 149) == 0) lo_left = $urandom_range(1, 3);
            l = (lo_left == 0);
            if (lo_left > 0) lo_left--;
            if (bt_left == 0 && $urandom_range(0, 79) == 0)
                bt_left = ($urandom_range(0, 9) == 0) ? 100 : $urandom_range(1, 10);
            b = (bt_left > 0);
            if (bt_left > 0) bt_left--;
            i = GATE ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) != 0);
            step(r, b, l, i);
        end

        for (int t = 0; t < 10 && exp_q.size() != 0; t++) @(negedge clk);
        #1;
        chk("scoreboard_drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
